// File: rtl/aha_prog_clk_div.sv
// Programmable integer clock divider with glitch-free start/stop and period-aligned ratio updates.
// Optional macro AHA_CLKDIV_ODD_DUTY50_EN adds a negedge stage for exact 50% duty on odd ratios.
module aha_prog_clk_div #(
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             CLK_IN,
   input  logic             RESET,
   input  logic             EN,
   input  logic [DIV_W-1:0] DIV_RATIO,
   input  logic             UPDATE_REQ,
   output logic             UPDATE_ACK,
   output logic [DIV_W-1:0] ACTIVE_RATIO,
   output logic             RUNNING,
   output logic             TICK,
   output logic             Q
);

   typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

   localparam logic [DIV_W-1:0] RESET_RATIO = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] MIN_RATIO   = DIV_W'(2);
   localparam logic [DIV_W-1:0] ONE         = DIV_W'(1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] active_q, active_d;
   logic [DIV_W-1:0] shadow_q, shadow_d;
   logic             pending_q, pending_d;
   logic             q_q, q_d;
   logic             tick_q, tick_d;
   logic             ack_q, ack_d;
   logic             running_q, running_d;

   logic             wrap;
   logic             copy_now;
   logic             capture;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      active_d  = active_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      tick_d    = 1'b0;
      ack_d     = 1'b0;

      wrap     = (state_q != IDLE) && (cnt_q == active_q - ONE);
      copy_now = pending_q && ((state_q == IDLE) || wrap);
      // A request arriving on the copy edge is captured after the old shadow is consumed.
      capture  = UPDATE_REQ && (!pending_q || copy_now);

      if (copy_now) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (capture) begin
         shadow_d  = (DIV_RATIO < MIN_RATIO) ? MIN_RATIO : DIV_RATIO;
         pending_d = 1'b1;
         ack_d     = 1'b1;
      end

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (EN) begin
               state_d = RUN;
               tick_d  = 1'b1;
            end
         end
         RUN: begin
            cnt_d  = wrap ? '0 : cnt_q + ONE;
            tick_d = wrap;
            if (!EN) state_d = STOPPING;
         end
         STOPPING: begin
            if (wrap && !EN) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d  = wrap ? '0 : cnt_q + ONE;
               tick_d = wrap;
               if (EN) state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      q_d       = (state_d != IDLE) && (cnt_d < (active_d >> 1));
      running_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         active_q  <= RESET_RATIO;
         shadow_q  <= RESET_RATIO;
         pending_q <= 1'b0;
         q_q       <= 1'b0;
         tick_q    <= 1'b0;
         ack_q     <= 1'b0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         q_q       <= q_d;
         tick_q    <= tick_d;
         ack_q     <= ack_d;
         running_q <= running_d;
      end
   end

`ifdef AHA_CLKDIV_ODD_DUTY50_EN
   logic neg_q;

   // Stretches the high phase by half a source cycle when the ratio is odd.
   always_ff @(negedge CLK_IN or posedge RESET) begin
      if (RESET) begin
         neg_q <= 1'b0;
      end else if (state_q == IDLE) begin
         neg_q <= 1'b0;
      end else begin
         neg_q <= q_q & active_q[0];
      end
   end

   assign Q = q_q | neg_q;
`else
   assign Q = q_q;
`endif

   assign UPDATE_ACK   = ack_q;
   assign ACTIVE_RATIO = active_q;
   assign RUNNING      = running_q;
   assign TICK         = tick_q;

endmodule

// File: tb/tb_aha_prog_clk_div.sv
// Directed self-checking bench for aha_prog_clk_div (DIV_W=8, DEFAULT_DIV=2).
module tb_aha_prog_clk_div;

   logic       CLK_IN = 1'b0;
   logic       RESET;
   logic       EN;
   logic [7:0] DIV_RATIO;
   logic       UPDATE_REQ;
   logic       UPDATE_ACK;
   logic [7:0] ACTIVE_RATIO;
   logic       RUNNING;
   logic       TICK;
   logic       Q;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc   = 0;

   aha_prog_clk_div #(.DIV_W(8), .DEFAULT_DIV(2)) dut (
      .CLK_IN       (CLK_IN),
      .RESET        (RESET),
      .EN           (EN),
      .DIV_RATIO    (DIV_RATIO),
      .UPDATE_REQ   (UPDATE_REQ),
      .UPDATE_ACK   (UPDATE_ACK),
      .ACTIVE_RATIO (ACTIVE_RATIO),
      .RUNNING      (RUNNING),
      .TICK         (TICK),
      .Q            (Q)
   );

   always #5 CLK_IN = ~CLK_IN;

   task automatic step();
      @(posedge CLK_IN);
      #1;
      cyc++;
      $display("cyc %0d: EN=%b REQ=%b DIV=%0d | Q=%b TICK=%b ACK=%b RUNNING=%b ACTIVE=%0d",
               cyc, EN, UPDATE_REQ, DIV_RATIO, Q, TICK, UPDATE_ACK, RUNNING, ACTIVE_RATIO);
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s @cyc %0d: observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s @cyc %0d: observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      logic [5:0] exp_q;
      logic [5:0] exp_t;
      logic [5:0] exp_r;

      RESET = 1'b1; EN = 1'b0; UPDATE_REQ = 1'b0; DIV_RATIO = 8'd0;
      step(); step();
      chk1("rst_q", Q, 1'b0);
      chk1("rst_tick", TICK, 1'b0);
      chk1("rst_ack", UPDATE_ACK, 1'b0);
      chk1("rst_running", RUNNING, 1'b0);
      chk8("rst_active", ACTIVE_RATIO, 8'd2);

      // Default divide-by-2 with EN high straight out of reset.
      RESET = 1'b0; EN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         chk1("div2_q", Q, (i % 2) == 0);
         chk1("div2_tick", TICK, (i % 2) == 0);
         chk1("div2_running", RUNNING, 1'b1);
      end
      chk8("div2_active", ACTIVE_RATIO, 8'd2);

      // Request N=5 on a wrap edge; applied at the following wrap.
      DIV_RATIO = 8'd5; UPDATE_REQ = 1'b1;
      step();
      chk1("req5_ack", UPDATE_ACK, 1'b1);
      chk1("req5_tick", TICK, 1'b1);
      chk8("req5_active_old", ACTIVE_RATIO, 8'd2);
      UPDATE_REQ = 1'b0;
      step();
      chk1("req5_ack_clear", UPDATE_ACK, 1'b0);
      chk8("req5_active_wait", ACTIVE_RATIO, 8'd2);
`ifdef AHA_CLKDIV_ODD_DUTY50_EN
      exp_q = 6'b111001;
`else
      exp_q = 6'b110001;
`endif
      exp_t = 6'b100001;
      for (int i = 0; i < 6; i++) begin
         step();
         chk1("div5_q", Q, exp_q[5-i]);
         chk1("div5_tick", TICK, exp_t[5-i]);
         chk8("div5_active", ACTIVE_RATIO, 8'd5);
      end

      // Move to N=6, then drop EN at cnt=1 and let the period finish.
      DIV_RATIO = 8'd6; UPDATE_REQ = 1'b1;
      step();
      chk1("req6_ack", UPDATE_ACK, 1'b1);
      UPDATE_REQ = 1'b0;
      step();
      chk1("req6_ack_clear", UPDATE_ACK, 1'b0);
      step();
      step();
      chk8("req6_active_wait", ACTIVE_RATIO, 8'd5);
      step();
      chk8("div6_active", ACTIVE_RATIO, 8'd6);
      chk1("div6_q0", Q, 1'b1);
      chk1("div6_tick0", TICK, 1'b1);
      step();
      chk1("div6_q1", Q, 1'b1);
      chk1("div6_tick1", TICK, 1'b0);
      EN = 1'b0;
      exp_q = 6'b100000;
      exp_r = 6'b111100;
      for (int i = 0; i < 6; i++) begin
         step();
         chk1("stop_q", Q, exp_q[5-i]);
         chk1("stop_running", RUNNING, exp_r[5-i]);
         chk1("stop_tick", TICK, 1'b0);
      end

      // Ratio clamp: 0 and 1 both become 2 (applied while idle).
      DIV_RATIO = 8'd0; UPDATE_REQ = 1'b1;
      step();
      chk1("clamp0_ack", UPDATE_ACK, 1'b1);
      UPDATE_REQ = 1'b0;
      step();
      chk8("clamp0_active", ACTIVE_RATIO, 8'd2);
      DIV_RATIO = 8'd1; UPDATE_REQ = 1'b1;
      step();
      chk1("clamp1_ack", UPDATE_ACK, 1'b1);
      UPDATE_REQ = 1'b0;
      step();
      chk8("clamp1_active", ACTIVE_RATIO, 8'd2);
      chk1("clamp1_idle", RUNNING, 1'b0);
      EN = 1'b1;
      step();
      chk1("restart_q", Q, 1'b1);
      chk1("restart_tick", TICK, 1'b1);
      chk1("restart_running", RUNNING, 1'b1);
      step();
      chk1("restart_q1", Q, 1'b0);
      step();
      chk1("restart_q2", Q, 1'b1);
      chk1("restart_tick2", TICK, 1'b1);

      // N=4 running, 3 pending, 7 held: ACK for 7 only on the wrap that applies 3.
      DIV_RATIO = 8'd4; UPDATE_REQ = 1'b1;
      step();
      chk1("req4_ack", UPDATE_ACK, 1'b1);
      UPDATE_REQ = 1'b0;
      step();
      chk8("div4_active", ACTIVE_RATIO, 8'd4);
      chk1("div4_tick", TICK, 1'b1);
      step();
      DIV_RATIO = 8'd3; UPDATE_REQ = 1'b1;
      step();
      chk1("req3_ack", UPDATE_ACK, 1'b1);
      DIV_RATIO = 8'd7;
      step();
      chk1("req7_no_ack", UPDATE_ACK, 1'b0);
      chk8("req7_active4", ACTIVE_RATIO, 8'd4);
      step();
      chk1("req7_ack", UPDATE_ACK, 1'b1);
      chk8("div3_active", ACTIVE_RATIO, 8'd3);
      chk1("div3_tick", TICK, 1'b1);
      chk1("div3_q", Q, 1'b1);
      UPDATE_REQ = 1'b0;
      step();
      chk1("req7_ack_clear", UPDATE_ACK, 1'b0);
      step();
      chk8("div3_active_hold", ACTIVE_RATIO, 8'd3);
      chk1("div3_tick_off", TICK, 1'b0);
      step();
      chk8("div7_active", ACTIVE_RATIO, 8'd7);
      chk1("div7_tick", TICK, 1'b1);

      // N=8 with an update pending at cnt=3, then asynchronous reset.
      DIV_RATIO = 8'd8; UPDATE_REQ = 1'b1;
      step();
      chk1("req8_ack", UPDATE_ACK, 1'b1);
      UPDATE_REQ = 1'b0;
      for (int i = 0; i < 5; i++) step();
      step();
      chk8("div8_active", ACTIVE_RATIO, 8'd8);
      chk1("div8_tick", TICK, 1'b1);
      step();
      step();
      DIV_RATIO = 8'd5; UPDATE_REQ = 1'b1;
      step();
      chk1("pend5_ack", UPDATE_ACK, 1'b1);
      chk1("div8_q_cnt3", Q, 1'b1);
      UPDATE_REQ = 1'b0;
      #2 RESET = 1'b1;
      #1;
      chk1("async_q", Q, 1'b0);
      chk1("async_running", RUNNING, 1'b0);
      chk8("async_active", ACTIVE_RATIO, 8'd2);
      step();
      RESET = 1'b0; EN = 1'b0;
      step();
      chk1("post_rst_q", Q, 1'b0);
      chk1("post_rst_running", RUNNING, 1'b0);
      step();
      chk8("post_rst_no_pending", ACTIVE_RATIO, 8'd2);
      EN = 1'b1;
      step();
      chk1("post_rst_start_q", Q, 1'b1);
      chk1("post_rst_start_tick", TICK, 1'b1);
      step();
      chk1("post_rst_q1", Q, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
